// File: rtl/e203_stim_seq.sv
// e203_stim_seq: parametrised stimulus sequencer (DUT reset, zeros, ones, walking-one, LFSR random) with match scoring
// Ports: clk/rst_n clock and async active-low reset; start/abort sequence control; tb_match bench compare result;
//        stim_o CH_NUM lanes of CH_W bits; stim_vld stimulus valid; dut_rst_n reset to the DUT; phase/busy/done status;
//        mismatch_cnt saturating mismatch count; first_fail_phase phase of first mismatch (7 = none).
module e203_stim_seq #(
  parameter int          CH_NUM    = 4,
  parameter int          CH_W      = 32,
  parameter int          HOLD      = 2,
  parameter int          RAND_ITER = 100,
  parameter int          RST_HOLD  = 2,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     tb_match,
  output logic [CH_NUM*CH_W-1:0]   stim_o,
  output logic                     stim_vld,
  output logic                     dut_rst_n,
  output logic [2:0]               phase,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              mismatch_cnt,
  output logic [2:0]               first_fail_phase
);
  localparam int W = CH_NUM * CH_W;
  typedef enum logic [2:0] {IDLE, RST, ZERO, ONES, WALK, RAND, DONE} phase_e;
  phase_e        phase_q, phase_d;
  logic [31:0]   hcnt_q, hcnt_d, scnt_q, scnt_d;
  logic [31:0]   lfsr_q [CH_NUM];
  logic [31:0]   lfsr_d [CH_NUM];
  logic [31:0]   lfsr_nx [CH_NUM];
  logic [W-1:0]  stim_q, stim_d, rand_now, rand_nx;
  logic          dut_rst_q;
  logic [15:0]   mm_q, mm_d;
  logic [2:0]    ffp_q, ffp_d;
  logic          last, score;
  function automatic logic [W-1:0] walk(input logic [31:0] s);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < CH_NUM; c++) v[c*CH_W +: CH_W] = CH_W'(1) << ((s + 32'(c)) % 32'(CH_W));
    return v;
  endfunction
  // Left-shifting Galois LFSR, feedback mask 32'h8020_0003
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    assign lfsr_nx[c] = {lfsr_q[c][30:0], 1'b0} ^ (lfsr_q[c][31] ? 32'h8020_0003 : 32'h0);
    assign rand_now[c*CH_W +: CH_W] = lfsr_q[c][CH_W-1:0];
    assign rand_nx[c*CH_W +: CH_W]  = lfsr_nx[c][CH_W-1:0];
  end
  assign last  = (phase_q == RST) ? (hcnt_q == 32'(RST_HOLD - 1)) : (hcnt_q == 32'(HOLD - 1));
  // The first cycle of each held value is DUT settle time and is never scored
  assign score = stim_vld && dut_rst_q && (hcnt_q != '0);
  always_comb begin
    phase_d = phase_q;
    hcnt_d  = last ? '0 : hcnt_q + 32'd1;
    scnt_d  = scnt_q;
    stim_d  = stim_q;
    lfsr_d  = lfsr_q;
    mm_d    = (score && !tb_match && mm_q != 16'hFFFF) ? mm_q + 16'd1 : mm_q;
    ffp_d   = (score && !tb_match && ffp_q == 3'd7) ? phase_q : ffp_q;
    if (abort) begin
      phase_d = IDLE;
      hcnt_d  = '0;
      scnt_d  = '0;
      stim_d  = '0;
    end else begin
      case (phase_q)
        IDLE, DONE: begin
          hcnt_d = '0;
          if (start) begin
            phase_d = RST;
            scnt_d  = '0;
            stim_d  = '0;
            mm_d    = '0;
            ffp_d   = 3'd7;
            for (int c = 0; c < CH_NUM; c++) lfsr_d[c] = LFSR_SEED + 32'(c) + 32'd1;
          end
        end
        RST:  if (last) phase_d = ZERO;
        ZERO: if (last) begin
          phase_d = ONES;
          stim_d  = '1;
        end
        ONES: if (last) begin
          phase_d = WALK;
          scnt_d  = '0;
          stim_d  = walk('0);
        end
        WALK: if (last) begin
          if (scnt_q == 32'(CH_W - 1)) begin
            phase_d = RAND;
            scnt_d  = '0;
            stim_d  = rand_now;
          end else begin
            scnt_d = scnt_q + 32'd1;
            stim_d = walk(scnt_q + 32'd1);
          end
        end
        RAND: if (last) begin
          lfsr_d = lfsr_nx;
          if (scnt_q == 32'(RAND_ITER - 1)) begin
            phase_d = DONE;
            stim_d  = '0;
          end else begin
            scnt_d = scnt_q + 32'd1;
            stim_d = rand_nx;
          end
        end
        default: phase_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= IDLE;
      hcnt_q    <= '0;
      scnt_q    <= '0;
      stim_q    <= '0;
      dut_rst_q <= 1'b0;
      mm_q      <= '0;
      ffp_q     <= 3'd7;
      for (int c = 0; c < CH_NUM; c++) lfsr_q[c] <= LFSR_SEED + 32'(c) + 32'd1;
    end else begin
      phase_q   <= phase_d;
      hcnt_q    <= hcnt_d;
      scnt_q    <= scnt_d;
      stim_q    <= stim_d;
      dut_rst_q <= (phase_d != RST);
      mm_q      <= mm_d;
      ffp_q     <= ffp_d;
      lfsr_q    <= lfsr_d;
    end
  end
  assign stim_o           = stim_q;
  assign stim_vld         = (phase_q == ZERO) || (phase_q == ONES) || (phase_q == WALK) || (phase_q == RAND);
  assign dut_rst_n        = dut_rst_q;
  assign phase            = phase_q;
  assign busy             = (phase_q != IDLE) && (phase_q != DONE);
  assign done             = (phase_q == DONE);
  assign mismatch_cnt     = mm_q;
  assign first_fail_phase = ffp_q;
endmodule

// File: tb/tb_e203_stim_seq.sv
// tb_e203_stim_seq: self-checking bench for e203_stim_seq against a cycle-indexed sequence model
module tb_e203_stim_seq;
  localparam int          CH_NUM    = 4;
  localparam int          CH_W      = 32;
  localparam int          HOLD      = 2;
  localparam int          RAND_ITER = 100;
  localparam int          RST_HOLD  = 2;
  localparam logic [31:0] SEED      = 32'h0000_0001;
  localparam int          W         = CH_NUM * CH_W;
  localparam int          TOTAL     = RST_HOLD + HOLD * (2 + CH_W + RAND_ITER);
  logic clk = 0, rst_n = 0, start = 0, abort = 0, tb_match = 1;
  logic [W-1:0] stim_o;
  logic         stim_vld, dut_rst_n, busy, done;
  logic [2:0]   phase, first_fail_phase;
  logic [15:0]  mismatch_cnt;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  e203_stim_seq #(
    .CH_NUM(CH_NUM), .CH_W(CH_W), .HOLD(HOLD), .RAND_ITER(RAND_ITER), .RST_HOLD(RST_HOLD), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tb_match(tb_match),
    .stim_o(stim_o), .stim_vld(stim_vld), .dut_rst_n(dut_rst_n), .phase(phase), .busy(busy),
    .done(done), .mismatch_cnt(mismatch_cnt), .first_fail_phase(first_fail_phase)
  );
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Random vectors per channel, precomputed by plain iteration of the LFSR rule
  logic [31:0] rv [RAND_ITER][CH_NUM];
  initial begin : lfsr_table
    logic [31:0] x;
    for (int c = 0; c < CH_NUM; c++) begin
      x = SEED + 32'(c) + 32'd1;
      for (int v = 0; v < RAND_ITER; v++) begin
        rv[v][c] = x;
        x = {x[30:0], 1'b0} ^ (x[31] ? 32'h8020_0003 : 32'h0);
      end
    end
  end
  // Model: busy cycle t maps to a held value index v = (t - RST_HOLD) / HOLD
  function automatic int vec(input int t);
    return (t - RST_HOLD) / HOLD;
  endfunction
  function automatic logic [2:0] exp_phase(input int t);
    int v;
    v = vec(t);
    return t < RST_HOLD ? 3'd1 : v < 1 ? 3'd2 : v < 2 ? 3'd3 : v < 2 + CH_W ? 3'd4 : 3'd5;
  endfunction
  function automatic logic [W-1:0] exp_stim(input int t);
    logic [W-1:0] s;
    int v;
    s = '0;
    v = vec(t);
    if (t >= RST_HOLD)
      for (int c = 0; c < CH_NUM; c++)
        if (v == 1) s[c*CH_W +: CH_W] = '1;
        else if (v >= 2 && v < 2 + CH_W) s[c*CH_W +: CH_W] = CH_W'(1) << ((v - 2 + c) % CH_W);
        else if (v >= 2 + CH_W) s[c*CH_W +: CH_W] = rv[v-2-CH_W][c][CH_W-1:0];
    return s;
  endfunction
  function automatic logic [CH_W-1:0] ch(input int c);
    return stim_o[c*CH_W +: CH_W];
  endfunction
  int          m_st, m_t;
  logic [15:0] m_mm;
  logic [2:0]  m_ffp;
  logic        armed;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= 0;
      m_t   <= 0;
      m_mm  <= '0;
      m_ffp <= 3'd7;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (m_st == 1 && m_t >= RST_HOLD && (m_t - RST_HOLD) % HOLD != 0 && !tb_match) begin
        if (m_mm != 16'hFFFF) m_mm <= m_mm + 16'd1;
        if (m_ffp == 3'd7) m_ffp <= exp_phase(m_t);
      end
      if (abort) m_st <= 0;
      else if (m_st != 1 && start) begin
        m_st  <= 1;
        m_t   <= 0;
        m_mm  <= '0;
        m_ffp <= 3'd7;
      end else if (m_st == 1) begin
        m_st <= (m_t == TOTAL - 1) ? 2 : 1;
        m_t  <= m_t + 1;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && armed) begin
      chk("stim", stim_o, m_st == 1 ? exp_stim(m_t) : '0);
      chk("phase", W'(phase), W'(m_st == 1 ? exp_phase(m_t) : m_st == 2 ? 3'd6 : 3'd0));
      chk("stim_vld", W'(stim_vld), W'(m_st == 1 && m_t >= RST_HOLD));
      chk("dut_rst_n", W'(dut_rst_n), W'(!(m_st == 1 && m_t < RST_HOLD)));
      chk("busy", W'(busy), W'(m_st == 1));
      chk("done", W'(done), W'(m_st == 2));
      chk("mismatch_cnt", W'(mismatch_cnt), W'(m_mm));
      chk("first_fail_phase", W'(first_fail_phase), W'(m_ffp));
    end
  end
  task automatic run(input bit lit, input int m0, input int m1, input int m2, input int ab,
                     input int ct, input logic [15:0] cmm, input logic [2:0] cff, output int nb);
    bit to;
    to = 1;
    nb = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) begin
        to = 0;
        break;
      end
      if (lit && nb == 0) begin
        chk("rst_low", W'(dut_rst_n), W'(0));
        chk("rst_phase", W'(phase), W'(1));
      end
      if (lit && nb == 2) begin
        chk("zero_rst_high", W'(dut_rst_n), W'(1));
        chk("zero_stim", stim_o, W'(0));
      end
      if (lit && nb == 4) chk("ones_stim", stim_o, {W{1'b1}});
      if (lit && nb == 6) begin
        chk("walk0_c0", W'(ch(0)), W'(32'h1));
        chk("walk0_c1", W'(ch(1)), W'(32'h2));
        chk("walk0_c2", W'(ch(2)), W'(32'h4));
        chk("walk0_c3", W'(ch(3)), W'(32'h8));
      end
      if (lit && nb == 68) begin
        chk("walk31_c0", W'(ch(0)), W'(32'h8000_0000));
        chk("walk31_c1", W'(ch(1)), W'(32'h1));
      end
      if (lit && (nb == 70 || nb == 71)) begin
        chk("rand0_c0", W'(ch(0)), W'(32'h2));
        chk("rand0_c1", W'(ch(1)), W'(32'h3));
      end
      if (lit && (nb == 72 || nb == 73)) begin
        chk("rand1_c0", W'(ch(0)), W'(32'h4));
        chk("rand1_c1", W'(ch(1)), W'(32'h6));
      end
      if (nb == ct) begin
        chk("mid_mismatch_cnt", W'(mismatch_cnt), W'(cmm));
        chk("mid_first_fail", W'(first_fail_phase), W'(cff));
      end
      tb_match = !(nb == m0 || nb == m1 || nb == m2);
      abort = (nb == ab);
      start = (nb == ab);
      nb++;
      @(negedge clk);
    end
    if (to) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: busy still high after %0d cycles, required drop", nb);
    end
    tb_match = 1;
    abort = 0;
    start = 0;
  endtask
  initial begin : stim
    int nb;
    repeat (2) @(negedge clk);
    chk("reset_stim", stim_o, W'(0));
    chk("reset_vld", W'(stim_vld), W'(0));
    chk("reset_dut_rst", W'(dut_rst_n), W'(0));
    chk("reset_phase", W'(phase), W'(0));
    chk("reset_busy_done", W'({busy, done}), W'(0));
    chk("reset_mm", W'(mismatch_cnt), W'(0));
    chk("reset_ffp", W'(first_fail_phase), W'(7));
    rst_n = 1;
    @(negedge clk);
    chk("idle_dut_rst", W'(dut_rst_n), W'(1));
    run(1, -1, -1, -1, -1, -1, 16'd0, 3'd0, nb);
    chk("run1_len", W'(nb), W'(270));
    chk("run1_done", W'({done, phase}), W'({1'b1, 3'd6}));
    chk("run1_mm", W'(mismatch_cnt), W'(0));
    chk("run1_ffp", W'(first_fail_phase), W'(7));
    run(0, 4, 5, 101, -1, 6, 16'd1, 3'd3, nb);
    chk("run2_len", W'(nb), W'(270));
    chk("run2_mm", W'(mismatch_cnt), W'(2));
    chk("run2_ffp", W'(first_fail_phase), W'(3));
    run(0, 89, -1, -1, 90, -1, 16'd0, 3'd0, nb);
    chk("abort_len", W'(nb), W'(91));
    chk("abort_phase", W'(phase), W'(0));
    chk("abort_stim", stim_o, W'(0));
    chk("abort_dut_rst", W'(dut_rst_n), W'(1));
    chk("abort_mm", W'(mismatch_cnt), W'(1));
    chk("abort_ffp", W'(first_fail_phase), W'(5));
    @(negedge clk);
    chk("abort_start_ignored", W'({busy, phase}), W'(0));
    run(0, -1, -1, -1, -1, -1, 16'd0, 3'd0, nb);
    chk("run4_len", W'(nb), W'(270));
    chk("run4_mm", W'(mismatch_cnt), W'(0));
    chk("run4_ffp", W'(first_fail_phase), W'(7));
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (3) @(negedge clk);
    tb_match = 0;
    repeat (6) @(negedge clk);
    tb_match = 1;
    chk("pre_rst_mm", W'(mismatch_cnt), W'(3));
    chk("pre_rst_ffp", W'(first_fail_phase), W'(2));
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_phase", W'(phase), W'(0));
    chk("async_stim", stim_o, W'(0));
    chk("async_dut_rst", W'(dut_rst_n), W'(0));
    chk("async_mm", W'(mismatch_cnt), W'(0));
    chk("async_ffp", W'(first_fail_phase), W'(7));
    @(negedge clk) rst_n = 1;
    repeat (3) @(negedge clk);
    chk("no_resume", W'({busy, phase}), W'(0));
    chk("post_rst_dut_rst", W'(dut_rst_n), W'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
